spi_word_master: RTL and testbench
==================================

Name: spi_word_master

Overview:
Downstream stage of the AXI-Lite read master in the AXI-Lite-to-SPI bridge. It takes one 32-bit word fetched over AXI-Lite and shifts it out over SPI in mode 0 (CPOL=0, CPHA=0), MSB first, full-duplex. It captures the word returned on MISO and hands it back to the bridge controller. It accepts words through a valid/ready handshake, so the controller can forward R_Data as soon as Reader_Run falls.

Parameters:
DATA_W, 32, shift word width in bits (legal range 8..32).
CLK_DIV, 2, ACLK cycles per SCLK half-period (legal value ≥1).

Ports:
ACLK  in  1  system clock; all logic on rising edge.
ARESETn  in  1  asynchronous active-low reset.
Tx_Valid  in  1  Tx_Data is valid.
Tx_Ready  out  1  block can accept a word; registered.
Tx_Data  in  DATA_W  word to transmit.
Rx_Valid  out  1  one-cycle pulse; Rx_Data updated.
Rx_Data  out  DATA_W  word captured from MISO; holds until the next Rx_Valid.
Busy  out  1  transfer in progress (from accept until Rx_Valid).
SCLK  out  1  SPI clock; idles low.
MOSI  out  1  SPI data out.
MISO  in  1  SPI data in.
CS_n  out  1  SPI chip select, active low.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - Tx_Ready=0, Rx_Valid=0, Rx_Data=0, Busy=0, SCLK=0, MOSI=0, CS_n=1.
  - Shift registers, bit counter and divider are cleared.
  - FSM goes to GAP.
- Reset mid-transfer aborts the transfer. No Rx_Valid is produced and the partial word is discarded.
- FSM states: GAP, IDLE, SETUP, SHIFT, HOLD.
- GAP (CS_n deselect time):
  - Count CLK_DIV cycles, then set Tx_Ready<=1 and go to IDLE.
  - Applies after reset release and after every transfer.
- IDLE:
  - Tx_Ready=1.
  - On a cycle with Tx_Valid&&Tx_Ready (the accept edge): latch Tx_Data into tx_sr; set MOSI<=Tx_Data[DATA_W-1], CS_n<=0, Busy<=1, Tx_Ready<=0; clear the divider; go to SETUP.
- SETUP:
  - Wait CLK_DIV cycles (CS_n-to-first-edge setup), then go to SHIFT.
- SHIFT:
  - The divider toggles SCLK every CLK_DIV cycles.
  - On the edge that drives SCLK 0→1: shift MISO into rx_sr LSB (rx_sr<={rx_sr[DATA_W-2:0],MISO}) and increment the bit counter.
  - On the edge that drives SCLK 1→0: if bits remain, shift tx_sr left and drive MOSI with the new MSB.
  - After the DATA_W-th falling edge (SCLK low), go to HOLD. MOSI keeps its last value.
  - Exactly DATA_W SCLK pulses per transfer.
- HOLD:
  - Wait CLK_DIV cycles.
  - Then set CS_n<=1, Busy<=0, Rx_Data<=rx_sr, Rx_Valid<=1 for exactly one cycle, MOSI<=0, and go to GAP.
- Timing:
  - CS_n is low for exactly (2*DATA_W+2)*CLK_DIV cycles.
  - Rx_Valid is asserted (2*DATA_W+2)*CLK_DIV cycles after the accept edge.
  - The next accept happens no earlier than CLK_DIV cycles after CS_n rises.
- Tx_Valid and Tx_Data are ignored while Tx_Ready=0. Tx_Data changes mid-transfer have no effect.
- Tx_Valid held high continuously gives back-to-back transfers separated only by GAP.
- MISO is sampled unsynchronised at the ACLK edge that raises SCLK. The slave must change MISO only after SCLK falls.
- No overflow or underflow conditions exist. The bit counter is sized ceil(log2(DATA_W+1)) and never wraps within a transfer.

Test Plan:
1. Reset with CLK_DIV=2, release ARESETn → all outputs at reset values; Tx_Ready rises exactly 2 cycles after release.
2. Tx_Data=0xA5C30F81 with MISO looped from MOSI → 32 SCLK pulses; MOSI bits match 0xA5C30F81 MSB first; CS_n low for 132 cycles; Rx_Valid pulses for 1 cycle; Rx_Data=0xA5C30F81.
3. MISO tied 1, then tied 0 → Rx_Data=0xFFFFFFFF, then 0x00000000; Rx_Data holds its value between pulses.
4. Tx_Valid held high with words 0x12345678 and 0xDEADBEEF, Tx_Data changed mid-transfer → first transfer unaffected by the change; second accept exactly 2 cycles after CS_n rises; both words returned correctly via loopback.
5. ARESETn asserted after the 10th SCLK rising edge → CS_n=1 and SCLK=0 immediately; no Rx_Valid; next transfer of 0x0000FFFF returns the correct value.
6. CLK_DIV=1, DATA_W=8, Tx_Data=0x3C with loopback → SCLK period of 2 cycles; CS_n low for 18 cycles; Rx_Data=0x3C.

Source files
------------

// File: rtl/spi_word_master.sv
// SPI mode-0 word master: shifts one DATA_W word out MSB first while capturing MISO,
// with valid/ready intake and a one-cycle Rx_Valid pulse carrying the returned word.
module spi_word_master #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 2
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              Tx_Valid,
    output logic              Tx_Ready,
    input  logic [DATA_W-1:0] Tx_Data,
    output logic              Rx_Valid,
    output logic [DATA_W-1:0] Rx_Data,
    output logic              Busy,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_GAP_C  = (CLK_DIV > 1) ? DIV_W'(1) : DIV_W'(0);
    localparam logic [CNT_W-1:0] BITS_C     = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        ST_GAP   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t            state_r;
    logic [DIV_W-1:0]  div_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] tx_sr_r;
    logic [DATA_W-1:0] rx_sr_r;
    logic              div_done_s;

    assign div_done_s = (div_r == DIV_LAST_C);

    // Transfer sequencer: owns every SPI pin, the handshake outputs and the shift registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r   <= ST_GAP;
            div_r     <= '0;
            bit_cnt_r <= '0;
            tx_sr_r   <= '0;
            rx_sr_r   <= '0;
            Tx_Ready  <= 1'b0;
            Rx_Valid  <= 1'b0;
            Rx_Data   <= '0;
            Busy      <= 1'b0;
            SCLK      <= 1'b0;
            MOSI      <= 1'b0;
            CS_n      <= 1'b1;
        end else begin
            Rx_Valid <= 1'b0;
            case (state_r)
                ST_GAP: begin
                    if (div_done_s) begin
                        div_r    <= '0;
                        Tx_Ready <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (Tx_Valid && Tx_Ready) begin
                        tx_sr_r   <= Tx_Data;
                        rx_sr_r   <= '0;
                        bit_cnt_r <= '0;
                        MOSI      <= Tx_Data[DATA_W-1];
                        CS_n      <= 1'b0;
                        Busy      <= 1'b1;
                        Tx_Ready  <= 1'b0;
                        div_r     <= '0;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_done_s) begin
                        div_r   <= '0;
                        state_r <= ST_SHIFT;
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (!div_done_s) begin
                        div_r <= div_r + DIV_W'(1);
                    end else if (!SCLK) begin
                        div_r     <= '0;
                        SCLK      <= 1'b1;
                        rx_sr_r   <= {rx_sr_r[DATA_W-2:0], MISO};
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end else begin
                        div_r <= '0;
                        SCLK  <= 1'b0;
                        // Last falling edge leaves MOSI on bit 0 through HOLD.
                        if (bit_cnt_r == BITS_C) begin
                            state_r <= ST_HOLD;
                        end else begin
                            tx_sr_r <= {tx_sr_r[DATA_W-2:0], 1'b0};
                            MOSI    <= tx_sr_r[DATA_W-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (div_done_s) begin
                        CS_n     <= 1'b1;
                        Busy     <= 1'b0;
                        Rx_Data  <= rx_sr_r;
                        Rx_Valid <= 1'b1;
                        MOSI     <= 1'b0;
                        // Deselect time counts from this edge, so the next accept
                        // lands exactly CLK_DIV cycles after CS_n rises.
                        if (CLK_DIV == 1) begin
                            div_r    <= '0;
                            Tx_Ready <= 1'b1;
                            state_r  <= ST_IDLE;
                        end else begin
                            div_r   <= DIV_GAP_C;
                            state_r <= ST_GAP;
                        end
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_GAP;
                    div_r    <= '0;
                    Tx_Ready <= 1'b0;
                    Busy     <= 1'b0;
                    SCLK     <= 1'b0;
                    MOSI     <= 1'b0;
                    CS_n     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_word_master.sv
// Bench for spi_word_master: a 32-bit/CLK_DIV=2 instance and an 8-bit/CLK_DIV=1 instance,
// each compared every cycle against a timeline model derived from cycles-since-accept.
module tb_spi_word_master;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        arst_n;
    logic        tv_a, tv_b;
    logic [31:0] td_a;
    logic [7:0]  td_b;
    logic        ready_a, rxv_a, busy_a, sclk_a, mosi_a, csn_a, miso_a;
    logic        ready_b, rxv_b, busy_b, sclk_b, mosi_b, csn_b, miso_b;
    logic [31:0] rxd_a;
    logic [7:0]  rxd_b;
    logic        loop_a, tie_a, loop_b, tie_b;

    assign miso_a = loop_a ? mosi_a : tie_a;
    assign miso_b = loop_b ? mosi_b : tie_b;

    spi_word_master #(.DATA_W(32), .CLK_DIV(2)) u_dut_a (
        .ACLK(aclk), .ARESETn(arst_n), .Tx_Valid(tv_a), .Tx_Ready(ready_a), .Tx_Data(td_a),
        .Rx_Valid(rxv_a), .Rx_Data(rxd_a), .Busy(busy_a), .SCLK(sclk_a), .MOSI(mosi_a),
        .MISO(miso_a), .CS_n(csn_a)
    );

    spi_word_master #(.DATA_W(8), .CLK_DIV(1)) u_dut_b (
        .ACLK(aclk), .ARESETn(arst_n), .Tx_Valid(tv_b), .Tx_Ready(ready_b), .Tx_Data(td_b),
        .Rx_Valid(rxv_b), .Rx_Data(rxd_b), .Busy(busy_b), .SCLK(sclk_b), .MOSI(mosi_b),
        .MISO(miso_b), .CS_n(csn_b)
    );

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int rel_cyc = 0;
    bit gap_chk = 1'b0;
    logic [31:0] lit_a[$];
    logic [31:0] lit_b[$];
    int low_n[2], pulse_n[2], hi_n[2];
    bit rdy_seen[2], prev_csn[2], prev_sclk[2];

    // SCLK is high during the first half of each 2*d period starting at cycle 2*d.
    function automatic logic f_sclk(input int t, input int w, input int d);
        if (t >= 2*d && t < (2*w + 1)*d) return (((t - 2*d) / d) % 2) == 0;
        return 1'b0;
    endfunction

    function automatic logic f_mosi(input int t, input logic [31:0] word, input int w, input int d);
        int fc;
        fc = (t < 3*d) ? 0 : (t - 3*d) / (2*d) + 1;
        if (fc > w - 1) fc = w - 1;
        return word[w - 1 - fc];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_model
        localparam int W = (g == 0) ? 32 : 8;
        localparam int D = (g == 0) ? 2 : 1;
        localparam int N = (2*W + 2) * D;
        localparam logic [31:0] MASK = (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);

        logic        tv_s, loop_s, tie_s;
        logic [31:0] td_s;
        assign tv_s   = (g == 0) ? tv_a : tv_b;
        assign td_s   = (g == 0) ? td_a : {24'd0, td_b};
        assign loop_s = (g == 0) ? loop_a : loop_b;
        assign tie_s  = (g == 0) ? tie_a : tie_b;

        logic        busy_m = 1'b0, ready_m = 1'b0, rxv_m = 1'b0;
        int          t_m = 0, gap_m = 0;
        logic [31:0] word_m = 32'd0, rxexp_m = 32'd0, rxd_m = 32'd0;

        always @(posedge aclk or negedge arst_n) begin
            if (!arst_n) begin
                busy_m <= 1'b0; ready_m <= 1'b0; rxv_m <= 1'b0;
                t_m <= 0; gap_m <= D;
                word_m <= 32'd0; rxexp_m <= 32'd0; rxd_m <= 32'd0;
            end else begin
                rxv_m <= 1'b0;
                if (busy_m) begin
                    if (t_m == N - 1) begin
                        busy_m <= 1'b0; t_m <= 0; rxv_m <= 1'b1; rxd_m <= rxexp_m;
                        gap_m <= D - 1; ready_m <= (D == 1);
                    end else begin
                        t_m <= t_m + 1;
                    end
                end else if (ready_m) begin
                    if (tv_s) begin
                        busy_m <= 1'b1; t_m <= 0; ready_m <= 1'b0;
                        word_m <= td_s & MASK;
                        rxexp_m <= loop_s ? (td_s & MASK) : (tie_s ? MASK : 32'd0);
                    end
                end else if (gap_m > 0) begin
                    gap_m <= gap_m - 1;
                    if (gap_m == 1) ready_m <= 1'b1;
                end
            end
        end

        logic exp_sclk, exp_mosi;
        assign exp_sclk = busy_m ? f_sclk(t_m, W, D) : 1'b0;
        assign exp_mosi = busy_m ? f_mosi(t_m, word_m, W, D) : 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic track(input int k, input bit gap_en, input logic csn, input logic sclk,
                         input logic ready, input int n_exp, input int p_exp, input int lat_exp);
        if (!arst_n) begin
            low_n[k] = 0; pulse_n[k] = 0; hi_n[k] = 0; rdy_seen[k] = 1'b0;
        end else begin
            if (!csn) begin
                if (prev_csn[k] && gap_en) chk("A.gap_len", 32'(hi_n[k]), 32'd2);
                low_n[k]++;
                if (sclk && !prev_sclk[k]) pulse_n[k]++;
                hi_n[k] = 0;
            end else begin
                if (!prev_csn[k]) begin
                    chk(k == 0 ? "A.cs_low_len" : "B.cs_low_len", 32'(low_n[k]), 32'(n_exp));
                    chk(k == 0 ? "A.sclk_pulses" : "B.sclk_pulses", 32'(pulse_n[k]), 32'(p_exp));
                end
                low_n[k] = 0; pulse_n[k] = 0; hi_n[k]++;
            end
            if (ready && !rdy_seen[k]) begin
                chk(k == 0 ? "A.ready_latency" : "B.ready_latency", 32'(cyc - rel_cyc), 32'(lat_exp));
                rdy_seen[k] = 1'b1;
            end
        end
        prev_csn[k] = csn;
        prev_sclk[k] = sclk;
    endtask

    // One sample per cycle, away from the active edge, for both instances.
    task automatic tick();
        @(negedge aclk);
        chk("A.Tx_Ready", 32'(ready_a), 32'(g_model[0].ready_m));
        chk("A.Busy",     32'(busy_a),  32'(g_model[0].busy_m));
        chk("A.CS_n",     32'(csn_a),   32'(!g_model[0].busy_m));
        chk("A.SCLK",     32'(sclk_a),  32'(g_model[0].exp_sclk));
        chk("A.MOSI",     32'(mosi_a),  32'(g_model[0].exp_mosi));
        chk("A.Rx_Valid", 32'(rxv_a),   32'(g_model[0].rxv_m));
        chk("A.Rx_Data",  rxd_a,        g_model[0].rxd_m);
        chk("B.Tx_Ready", 32'(ready_b), 32'(g_model[1].ready_m));
        chk("B.Busy",     32'(busy_b),  32'(g_model[1].busy_m));
        chk("B.CS_n",     32'(csn_b),   32'(!g_model[1].busy_m));
        chk("B.SCLK",     32'(sclk_b),  32'(g_model[1].exp_sclk));
        chk("B.MOSI",     32'(mosi_b),  32'(g_model[1].exp_mosi));
        chk("B.Rx_Valid", 32'(rxv_b),   32'(g_model[1].rxv_m));
        chk("B.Rx_Data",  32'(rxd_b),   g_model[1].rxd_m);
        if (arst_n && rxv_a) begin
            if (lit_a.size() > 0) chk("A.rx_word", rxd_a, lit_a.pop_front());
            else chk("A.rx_unexpected", 32'(rxv_a), 32'd0);
        end
        if (arst_n && rxv_b) begin
            if (lit_b.size() > 0) chk("B.rx_word", 32'(rxd_b), lit_b.pop_front());
            else chk("B.rx_unexpected", 32'(rxv_b), 32'd0);
        end
        track(0, gap_chk, csn_a, sclk_a, ready_a, 132, 32, 2);
        track(1, 1'b0, csn_b, sclk_b, ready_b, 18, 8, 1);
    endtask

    task automatic wait_busy(input int k, input logic want);
        int n;
        n = 0;
        while (((k == 0) ? busy_a : busy_b) !== want && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk(k == 0 ? "A.busy_wait" : "B.busy_wait",
                           32'((k == 0) ? busy_a : busy_b), 32'(want));
    endtask

    task automatic send_a(input logic [31:0] w, input logic [31:0] rx_exp);
        td_a = w;
        tv_a = 1'b1;
        lit_a.push_back(rx_exp);
        wait_busy(0, 1'b1);
        tv_a = 1'b0;
        wait_busy(0, 1'b0);
        repeat (4) tick();
    endtask

    initial begin
        arst_n = 1'b0;
        tv_a = 1'b0; td_a = 32'd0; loop_a = 1'b1; tie_a = 1'b0;
        tv_b = 1'b0; td_b = 8'd0;  loop_b = 1'b1; tie_b = 1'b0;
        @(posedge aclk);
        tick();
        chk("A.reset_CS_n", 32'(csn_a), 32'd1);
        chk("A.reset_Tx_Ready", 32'(ready_a), 32'd0);
        chk("A.reset_Rx_Data", rxd_a, 32'd0);
        repeat (2) tick();
        @(posedge aclk); #1 arst_n = 1'b1; rel_cyc = cyc;
        repeat (4) tick();

        // Loopback of a mixed pattern.
        loop_a = 1'b1;
        send_a(32'hA5C3_0F81, 32'hA5C3_0F81);

        // MISO tied high then low; the returned word must hold between pulses.
        loop_a = 1'b0; tie_a = 1'b1;
        send_a(32'h1357_9BDF, 32'hFFFF_FFFF);
        repeat (10) tick();
        chk("A.rx_hold", rxd_a, 32'hFFFF_FFFF);
        tie_a = 1'b0;
        send_a(32'hFFFF_FFFF, 32'h0000_0000);

        // Back-to-back with Tx_Valid held; Tx_Data changes mid-transfer.
        loop_a = 1'b1;
        td_a = 32'h1234_5678; tv_a = 1'b1;
        lit_a.push_back(32'h1234_5678);
        lit_a.push_back(32'hDEAD_BEEF);
        wait_busy(0, 1'b1);
        gap_chk = 1'b1;
        repeat (20) tick();
        td_a = 32'hDEAD_BEEF;
        wait_busy(0, 1'b0);
        wait_busy(0, 1'b1);
        gap_chk = 1'b0;
        tv_a = 1'b0;
        wait_busy(0, 1'b0);
        repeat (4) tick();

        // Abort after the 10th SCLK rise.
        td_a = 32'hCAFE_F00D; tv_a = 1'b1;
        wait_busy(0, 1'b1);
        tv_a = 1'b0;
        repeat (40) tick();
        chk("A.tenth_rise_sclk", 32'(sclk_a), 32'd1);
        @(posedge aclk); #1 arst_n = 1'b0;
        tick();
        chk("A.abort_CS_n", 32'(csn_a), 32'd1);
        chk("A.abort_SCLK", 32'(sclk_a), 32'd0);
        chk("A.abort_Busy", 32'(busy_a), 32'd0);
        repeat (2) tick();
        @(posedge aclk); #1 arst_n = 1'b1; rel_cyc = cyc;
        repeat (4) tick();
        send_a(32'h0000_FFFF, 32'h0000_FFFF);

        // 8-bit instance, CLK_DIV=1.
        td_b = 8'h3C; tv_b = 1'b1;
        lit_b.push_back(32'h0000_003C);
        wait_busy(1, 1'b1);
        tv_b = 1'b0;
        wait_busy(1, 1'b0);
        repeat (4) tick();
        chk("B.rx_final", 32'(rxd_b), 32'h0000_003C);

        chk("A.rx_pending", 32'(lit_a.size()), 32'd0);
        chk("B.rx_pending", 32'(lit_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
